fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port i_stall, input, 1 bit: hazard hold; the PC and the output register keep their values.
REQ-004 SHALL have port i_branch_taken, input, 1 bit: redirect request from a later stage.
REQ-005 SHALL have port i_branch_addr, input, 32 bits: redirect target.
REQ-006 SHALL have port i_interrupt, input, 1 bit: external interrupt request, level-sampled.
REQ-007 SHALL have port i_imem_data, input, 16 bits: instruction memory read data, combinational from o_imem_addr.
REQ-008 SHALL have port o_imem_addr, output, 32 bits: instruction memory word address.
REQ-009 SHALL have port o_instr, output, 16 bits: registered instruction to decode; 16'h0000 = NOP.
REQ-010 SHALL have port o_pc, output, 32 bits: registered PC+1 of the instruction in o_instr.
REQ-011 SHALL have port o_interrupt, output, 1 bit: registered interrupt marker to decode.

Function
REQ-012 SHALL implement states BOOT_LO, BOOT_HI, RUN, INT_LO, INT_HI.
REQ-013 BOOT_LO SHALL drive o_imem_addr=0, latch i_imem_data into pc[15:0], and go to BOOT_HI.
REQ-014 BOOT_HI SHALL drive o_imem_addr=1, latch i_imem_data into pc[31:16], and go to RUN.
REQ-015 In BOOT_LO and BOOT_HI, o_instr SHALL be NOP and o_interrupt 0; i_stall and i_branch_taken SHALL be ignored.
REQ-016 In RUN, o_imem_addr SHALL equal pc.
REQ-017 In RUN, each non-stalled cycle SHALL register o_instr=i_imem_data and o_pc=pc+1 (32-bit wrap, 32'hFFFFFFFF+1=0) and set pc=pc+1; latency 1 cycle.
REQ-018 In RUN with i_stall=1 and no branch, pc, o_instr, o_pc and o_interrupt SHALL hold.
REQ-019 In RUN, i_branch_taken=1 SHALL override i_stall: set pc=i_branch_addr and o_instr=NOP next cycle.
REQ-020 A rising i_interrupt SHALL set a pending flag.
REQ-021 The pending flag SHALL clear only when the interrupt is accepted.
REQ-022 In RUN, a pending interrupt SHALL be accepted only on a cycle with i_stall=0 and i_branch_taken=0.
REQ-023 On acceptance: o_instr=NOP, o_interrupt=1 for one cycle, o_pc=pc (the unfetched return address), pc unchanged, next state INT_LO.
REQ-024 INT_LO/INT_HI SHALL read vector words at addresses 2 and 3 into pc[15:0]/pc[31:16], emit NOP with o_interrupt=0, then return to RUN.
REQ-025 On branch and interrupt in the same cycle, the branch SHALL win and the interrupt SHALL stay pending.
REQ-026 A new interrupt edge while in INT_LO/INT_HI SHALL be latched as pending; no nesting mid-vector-load.

Reset
REQ-027 Assertion of i_reset SHALL immediately set state=BOOT_LO, pc=0, o_instr=16'h0000, o_pc=0, o_interrupt=0 and clear pending, including mid-boot or mid-vector-load.
REQ-028 After deassertion, the first RUN fetch SHALL occur on the third rising edge.

Configuration
REQ-029 With macro FETCH_INTERRUPT_EN defined, REQ-020..REQ-026 SHALL apply.
REQ-030 Without FETCH_INTERRUPT_EN, i_interrupt SHALL be ignored, o_interrupt SHALL be constant 0, and states INT_LO/INT_HI and the pending flag SHALL not exist.

Verification
REQ-031 Reset; mem[0]=16'h0010, mem[1]=0 -> o_imem_addr 0,1, then 16'h0010; first o_instr=mem[16], o_pc=17.
REQ-032 RUN at pc=20, i_stall high 3 cycles -> o_instr/o_pc frozen, o_imem_addr=20 throughout; fetch resumes from 20.
REQ-033 i_stall=1 and i_branch_taken=1 with i_branch_addr=32'h100 -> next o_instr=NOP; next fetch address 32'h100.
REQ-034 Interrupt at pc=40, mem[2]=16'h0200, mem[3]=0 -> one NOP with o_interrupt=1 and o_pc=40, then 2 NOPs, then fetch at 32'h200.
REQ-035 Interrupt coincident with a branch to 32'h80 -> redirect to 32'h80 first; interrupt accepted next free cycle with o_pc=32'h80.
REQ-036 pc=32'hFFFFFFFF, no stall -> o_pc=0, next o_imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage for a 16-bit instruction / 32-bit
//             address pipeline. After reset the PC is loaded from the
//             boot words at instruction-memory addresses 0 (low half) and
//             1 (high half). Instructions are then fetched one per cycle
//             into a registered output stage. The stage supports hazard
//             stalls and branch redirects. When FETCH_INTERRUPT_EN is
//             defined, it also supports edge-latched interrupts that
//             vector through the words at addresses 2 and 3.
//  Config   : FETCH_INTERRUPT_EN - enables the interrupt path
//             (pending flag, INT_LO/INT_HI states, o_interrupt marker).
//  Ports    :
//    i_clk          in   1  clock, rising edge
//    i_reset        in   1  asynchronous active-high reset
//    i_stall        in   1  hazard hold (RUN only)
//    i_branch_taken in   1  redirect request, overrides stall
//    i_branch_addr  in  32  redirect target
//    i_interrupt    in   1  interrupt request, level-sampled
//    i_imem_data    in  16  instruction memory data (combinational)
//    o_imem_addr    out 32  instruction memory word address
//    o_instr        out 16  registered instruction (16'h0000 = NOP)
//    o_pc           out 32  registered PC+1 of o_instr
//    o_interrupt    out  1  registered interrupt marker
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_addr,
    input  logic        i_interrupt,
    input  logic [15:0] i_imem_data,
    output logic [31:0] o_imem_addr,
    output logic [15:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_interrupt
);

    localparam logic [15:0] NOP = 16'h0000;

`ifdef FETCH_INTERRUPT_EN
    typedef enum logic [2:0] {
        BOOT_LO = 3'd0,
        BOOT_HI = 3'd1,
        RUN     = 3'd2,
        INT_LO  = 3'd3,
        INT_HI  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT_LO = 2'd0,
        BOOT_HI = 2'd1,
        RUN     = 2'd2
    } state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [15:0] instr_q;
    logic [31:0] opc_q;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd1;

`ifdef FETCH_INTERRUPT_EN
    logic oint_q;
    logic pend_q;
    logic int_prev_q;
    logic pend_d;
    logic int_rise;
    logic accept;

    assign int_rise = i_interrupt & ~int_prev_q;
    // A pending interrupt is taken only on a cycle that would otherwise
    // fetch; a stall or a branch leaves it pending.
    assign accept   = (state_q == RUN) & pend_q & ~i_stall & ~i_branch_taken;
    // A new edge wins over the clear, so an edge arriving in the same
    // cycle as an acceptance is not lost.
    assign pend_d   = int_rise | (pend_q & ~accept);
    assign o_interrupt = oint_q;
`else
    logic unused_interrupt;
    assign unused_interrupt = i_interrupt;
    assign o_interrupt      = 1'b0;
`endif

    // Memory address: fixed boot/vector word addresses outside RUN.
    always_comb begin
        o_imem_addr = pc_q;
        case (state_q)
            BOOT_LO: o_imem_addr = 32'd0;
            BOOT_HI: o_imem_addr = 32'd1;
`ifdef FETCH_INTERRUPT_EN
            INT_LO:  o_imem_addr = 32'd2;
            INT_HI:  o_imem_addr = 32'd3;
`endif
            default: o_imem_addr = pc_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= BOOT_LO;
            pc_q       <= 32'd0;
            instr_q    <= NOP;
            opc_q      <= 32'd0;
`ifdef FETCH_INTERRUPT_EN
            oint_q     <= 1'b0;
            pend_q     <= 1'b0;
            int_prev_q <= 1'b0;
`endif
        end else begin
`ifdef FETCH_INTERRUPT_EN
            int_prev_q <= i_interrupt;
            pend_q     <= pend_d;
`endif
            case (state_q)
                BOOT_LO: begin
                    pc_q[15:0] <= i_imem_data;
                    instr_q    <= NOP;
`ifdef FETCH_INTERRUPT_EN
                    oint_q     <= 1'b0;
`endif
                    state_q    <= BOOT_HI;
                end
                BOOT_HI: begin
                    pc_q[31:16] <= i_imem_data;
                    instr_q     <= NOP;
`ifdef FETCH_INTERRUPT_EN
                    oint_q      <= 1'b0;
`endif
                    state_q     <= RUN;
                end
                RUN: begin
                    if (i_branch_taken) begin
                        // Redirect squashes whatever is at the old PC.
                        pc_q    <= i_branch_addr;
                        instr_q <= NOP;
`ifdef FETCH_INTERRUPT_EN
                        oint_q  <= 1'b0;
`endif
                    end
`ifdef FETCH_INTERRUPT_EN
                    else if (accept) begin
                        // Return address is the instruction not yet fetched.
                        instr_q <= NOP;
                        oint_q  <= 1'b1;
                        opc_q   <= pc_q;
                        state_q <= INT_LO;
                    end
`endif
                    else if (!i_stall) begin
                        instr_q <= i_imem_data;
                        opc_q   <= pc_inc;
                        pc_q    <= pc_inc;
`ifdef FETCH_INTERRUPT_EN
                        oint_q  <= 1'b0;
`endif
                    end
                end
`ifdef FETCH_INTERRUPT_EN
                INT_LO: begin
                    pc_q[15:0] <= i_imem_data;
                    instr_q    <= NOP;
                    oint_q     <= 1'b0;
                    state_q    <= INT_HI;
                end
                INT_HI: begin
                    pc_q[31:16] <= i_imem_data;
                    instr_q     <= NOP;
                    oint_q      <= 1'b0;
                    state_q     <= RUN;
                end
`endif
                default: begin
                    state_q <= BOOT_LO;
                end
            endcase
        end
    end

    assign o_instr = instr_q;
    assign o_pc    = opc_q;

endmodule
`default_nettype wire
